// File: rtl/seven_seg_display_ctrl_if.sv
// Load channel for the seven-segment controller: one display update
// (digits, decimal points, blanking) carried by a valid/ready handshake.
interface seven_seg_display_ctrl_if;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        load_valid;
  logic        load_ready;

  modport master (
    output value,
    output dp_in,
    output blank_in,
    output load_valid,
    input  load_ready
  );

  modport slave (
    input  value,
    input  dp_in,
    input  blank_in,
    input  load_valid,
    output load_ready
  );
endinterface

// File: rtl/seven_seg_display_ctrl.sv
// Four-digit multiplexed seven-segment driver with a double-buffered
// display image, per-digit blanking/decimal points and PWM brightness.
module seven_seg_display_ctrl #(
  parameter int SCAN_DIV = 100000
) (
  input  logic                     clk,
  input  logic                     reset,
  seven_seg_display_ctrl_if.slave  load_bus,
  input  logic [3:0]               brightness,
  output logic [3:0]               anode,
  output logic [6:0]               cathode,
  output logic                     dp,
  output logic                     frame_start
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] count;
  logic [1:0]    index;
  logic [3:0]    pwm;

  logic [15:0]   pend_value;
  logic [3:0]    pend_dp;
  logic [3:0]    pend_blank;
  logic          pend_valid;

  logic [15:0]   act_value;
  logic [3:0]    act_dp;
  logic [3:0]    act_blank;

  logic          tick;
  logic          boundary;
  logic          accept;
  logic          lit;
  logic [3:0]    nibble;
  logic [3:0]    anode_next;
  logic [6:0]    seg_next;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Handshake: a load transfers on any cycle where load_valid and load_ready
  // are both high; the source must hold value/dp_in/blank_in stable until then.
  assign load_bus.load_ready = ~pend_valid;

  always_comb begin
    tick       = (count == LAST);
    boundary   = tick && (index == 2'd3);
    accept     = load_bus.load_valid && !pend_valid;
    lit        = (pwm <= brightness);
    nibble     = act_value[{index, 2'b00} +: 4];
    seg_next   = hex_to_seg(nibble);
    anode_next = 4'b1111;
    if (lit && !act_blank[index]) anode_next[index] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
      index <= 2'd0;
      pwm   <= 4'd0;
    end else begin
      count <= tick ? '0 : count + CW'(1);
      if (tick) index <= index + 2'd1;
      pwm <= pwm + 4'd1;
    end
  end

  // A load landing on the boundary cycle only fills pending; it is copied
  // to active at the following boundary, so a frame is never torn.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_value <= 16'h0000;
      pend_dp    <= 4'b0000;
      pend_blank <= 4'b0000;
      pend_valid <= 1'b0;
      act_value  <= 16'h0000;
      act_dp     <= 4'b0000;
      act_blank  <= 4'b1111;
    end else begin
      if (boundary && pend_valid) begin
        act_value  <= pend_value;
        act_dp     <= pend_dp;
        act_blank  <= pend_blank;
        pend_valid <= 1'b0;
      end else if (accept) begin
        pend_value <= load_bus.value;
        pend_dp    <= load_bus.dp_in;
        pend_blank <= load_bus.blank_in;
        pend_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      anode       <= 4'b1111;
      cathode     <= 7'b1111111;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      anode       <= anode_next;
      cathode     <= seg_next;
      dp          <= ~act_dp[index];
      frame_start <= boundary;
    end
  end

endmodule

// File: tb/tb_seven_seg_display_ctrl.sv
// Directed bench for seven_seg_display_ctrl: a SCAN_DIV=4 instance for scan,
// load, blanking and reset behaviour, and a SCAN_DIV=16 instance for PWM.
module tb_seven_seg_display_ctrl;

  logic clk;
  logic reset;
  logic [3:0] brightness4, brightness16;
  logic [3:0] anode4, anode16;
  logic [6:0] cathode4, cathode16;
  logic dp4, dp16;
  logic fs4, fs16;

  int checks = 0;
  int passed = 0;

  logic [6:0] seg_tab [16];
  logic [31:0] exp_q[$];

  seven_seg_display_ctrl_if bus4 ();
  seven_seg_display_ctrl_if bus16 ();

  seven_seg_display_ctrl #(.SCAN_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .load_bus(bus4), .brightness(brightness4),
    .anode(anode4), .cathode(cathode4), .dp(dp4), .frame_start(fs4)
  );

  seven_seg_display_ctrl #(.SCAN_DIV(16)) dut16 (
    .clk(clk), .reset(reset), .load_bus(bus16), .brightness(brightness16),
    .anode(anode16), .cathode(cathode16), .dp(dp16), .frame_start(fs16)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic wait_fs(input int which, input int limit);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (((which == 4) ? fs4 : fs16) !== 1'b1 && n < limit);
    if (((which == 4) ? fs4 : fs16) !== 1'b1) check("fs_timeout", 32'd0, 32'd1);
  endtask

  task automatic drive_load4(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    bus4.value = v;
    bus4.dp_in = d;
    bus4.blank_in = b;
    bus4.load_valid = 1'b1;
  endtask

  function automatic logic [3:0] anode_for(input int d);
    logic [3:0] a;
    a = 4'b1111;
    a[d] = 1'b0;
    return a;
  endfunction

  initial begin
    int bad;
    int lows;
    int d;
    logic [15:0] v;
    logic [3:0] nib;

    seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
    seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
    seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
    seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
    seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
    seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
    seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
    seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;

    reset = 1'b0;
    brightness4 = 4'd15;
    brightness16 = 4'd3;
    bus4.value = '0; bus4.dp_in = '0; bus4.blank_in = '0; bus4.load_valid = 1'b0;
    bus16.value = '0; bus16.dp_in = '0; bus16.blank_in = '0; bus16.load_valid = 1'b0;
    repeat (3) step();
    reset = 1'b1;

    // reset values
    check("rst_anode", {28'd0, anode4}, 32'hF);
    check("rst_cathode", {25'd0, cathode4}, 32'h7F);
    check("rst_dp", {31'd0, dp4}, 32'd1);
    check("rst_fs", {31'd0, fs4}, 32'd0);
    check("rst_ready", {31'd0, bus4.load_ready}, 32'd1);

    // PWM instance: only digit 0 enabled, brightness 3
    bus16.value = 16'h0008;
    bus16.blank_in = 4'b1110;
    bus16.load_valid = 1'b1;

    // idle scan: dark, frame_start every 16 cycles
    bad = 0;
    for (int i = 1; i <= 32; i++) begin
      step();
      if (i == 1) begin
        check("pwm_load_taken", {31'd0, bus16.load_ready}, 32'd0);
        bus16.load_valid = 1'b0;
      end
      if (anode4 !== 4'b1111) bad++;
      if (fs4 !== ((i % 16) == 0)) bad++;
      if (bus4.load_ready !== 1'b1) bad++;
    end
    check("idle_scan", bad, 0);

    // brightness 3 on SCAN_DIV=16: digit 0 lit for pwm 0..3 only
    wait_fs(16, 200);
    lows = 0;
    for (int k = 1; k <= 64; k++) begin
      step();
      if (anode16 === 4'b1110) lows++;
      check("pwm_anode", {28'd0, anode16}, (k <= 4) ? 32'hE : 32'hF);
    end
    check("pwm_low_count", lows, 4);

    // load 1234 at full brightness
    wait_fs(4, 100);
    drive_load4(16'h1234, 4'b0000, 4'b0000);
    step();
    check("ld_ready_fall", {31'd0, bus4.load_ready}, 32'd0);
    bus4.load_valid = 1'b0;
    wait_fs(4, 100);
    check("ld_ready_rise", {31'd0, bus4.load_ready}, 32'd1);
    v = 16'h1234;
    for (int k = 1; k <= 16; k++) begin
      step();
      d = (k - 1) / 4;
      nib = v[4*d +: 4];
      check("scan_anode", {28'd0, anode4}, {28'd0, anode_for(d)});
      check("scan_cathode", {25'd0, cathode4}, {25'd0, seg_tab[nib]});
    end
    check("scan_dp", {31'd0, dp4}, 32'd1);

    // back-to-back loads with load_valid held
    wait_fs(4, 100);
    drive_load4(16'h1111, 4'b0000, 4'b0000);
    step();
    check("b2b_first_taken", {31'd0, bus4.load_ready}, 32'd0);
    bus4.value = 16'h2222;
    bad = 0;
    for (int k = 2; k <= 16; k++) begin
      step();
      if (k < 16 && bus4.load_ready !== 1'b0) bad++;
    end
    check("b2b_held_off", bad, 0);
    check("b2b_boundary_fs", {31'd0, fs4}, 32'd1);
    check("b2b_ready_back", {31'd0, bus4.load_ready}, 32'd1);
    step();
    check("b2b_second_taken", {31'd0, bus4.load_ready}, 32'd0);
    bus4.load_valid = 1'b0;
    for (int j = 0; j < 32; j++) exp_q.push_back({25'd0, seg_tab[(j < 16) ? 1 : 2]});
    while (exp_q.size() > 0) begin
      check("b2b_cathode", {25'd0, cathode4}, exp_q.pop_front());
      step();
    end

    // blanking on digit 2, decimal point on digit 0
    wait_fs(4, 100);
    drive_load4(16'h5678, 4'b0001, 4'b0100);
    step();
    bus4.load_valid = 1'b0;
    wait_fs(4, 100);
    v = 16'h5678;
    for (int k = 1; k <= 16; k++) begin
      step();
      d = (k - 1) / 4;
      nib = v[4*d +: 4];
      check("blank_anode", {28'd0, anode4}, (d == 2) ? 32'hF : {28'd0, anode_for(d)});
      check("blank_dp", {31'd0, dp4}, (d == 0) ? 32'd0 : 32'd1);
      check("blank_cathode", {25'd0, cathode4}, {25'd0, seg_tab[nib]});
    end

    // reset mid-frame with a load pending
    wait_fs(4, 100);
    drive_load4(16'h9999, 4'b1111, 4'b0000);
    step();
    bus4.load_valid = 1'b0;
    check("mid_pending", {31'd0, bus4.load_ready}, 32'd0);
    repeat (4) step();
    reset = 1'b0;
    step();
    check("mid_rst_anode", {28'd0, anode4}, 32'hF);
    check("mid_rst_ready", {31'd0, bus4.load_ready}, 32'd1);
    check("mid_rst_cathode", {25'd0, cathode4}, 32'h7F);
    check("mid_rst_fs", {31'd0, fs4}, 32'd0);
    reset = 1'b1;
    bad = 0;
    for (int i = 1; i <= 48; i++) begin
      step();
      if (anode4 !== 4'b1111) bad++;
      if (fs4 !== ((i % 16) == 0)) bad++;
      if (bus4.load_ready !== 1'b1) bad++;
    end
    check("mid_stays_dark", bad, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
